// File: rtl/reaction_game_ctrl_if.sv
// Signal bundle between the reaction game round controller and its
// button/LFSR sources and display/decoder consumers.
interface reaction_game_ctrl_if;
  logic        start;
  logic        react;
  logic [11:0] rnd;
  logic        led;
  logic        busy;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;
  logic [13:0] best_ms;
  logic [2:0]  state;

  modport master (
    output start, react, rnd,
    input  led, busy, result_ms, result_valid, false_start, timeout, best_ms, state
  );

  modport slave (
    input  start, react, rnd,
    output led, busy, result_ms, result_valid, false_start, timeout, best_ms, state
  );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction timer round controller: random pre-stimulus delay, ms reaction
// timing, false-start/timeout detection and best-time tracking.
module reaction_game_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int TIMEOUT_MS   = 9999
) (
  input logic                 cin,
  input logic                 rst,
  reaction_game_ctrl_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GO    = 3'd2,
    SHOW  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic          start_q_reg, react_q_reg;
  logic          start_e, react_e;
  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic [13:0]   ms_cnt_reg, ms_cnt_next;
  logic [12:0]   delay_ms_reg, delay_ms_next;
  logic          tick, delay_done, timeout_hit, entering;

  logic          led_reg, led_next;
  logic          busy_reg, busy_next;
  logic [13:0]   result_ms_reg, result_ms_next;
  logic          result_valid_reg, result_valid_next;
  logic          false_start_reg, false_start_next;
  logic          timeout_reg, timeout_next;
  logic [13:0]   best_ms_reg, best_ms_next;

  assign start_e     = bus.start & ~start_q_reg;
  assign react_e     = bus.react & ~react_q_reg;
  assign tick        = (prescaler_reg == PW'(TICK_DIV - 1));
  assign delay_done  = tick && (ms_cnt_reg == ({1'b0, delay_ms_reg} - 14'd1));
  assign timeout_hit = tick && (ms_cnt_reg == 14'(TIMEOUT_MS - 1));
  assign entering    = (state_next != state_reg) &&
                       ((state_next == WAIT) || (state_next == GO));

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A press always beats a coincident delay-expiry or timeout tick.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, SHOW, FAULT: begin
        if (start_e) state_next = WAIT;
      end
      WAIT: begin
        if (react_e)         state_next = FAULT;
        else if (delay_done) state_next = GO;
      end
      GO: begin
        if (react_e)          state_next = SHOW;
        else if (timeout_hit) state_next = FAULT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    led_next          = (state_next == GO);
    busy_next         = (state_next == WAIT) || (state_next == GO);
    result_ms_next    = result_ms_reg;
    result_valid_next = result_valid_reg;
    false_start_next  = false_start_reg;
    timeout_next      = timeout_reg;
    best_ms_next      = best_ms_reg;
    delay_ms_next     = delay_ms_reg;
    case (state_reg)
      IDLE, SHOW, FAULT: begin
        // result_ms is stable throughout SHOW, so best lands one cycle after entry
        if ((state_reg == SHOW) && (result_ms_reg < best_ms_reg)) begin
          best_ms_next = result_ms_reg;
        end
        if (start_e) begin
          delay_ms_next     = 13'(MIN_DELAY_MS) + {1'b0, bus.rnd};
          result_valid_next = 1'b0;
          false_start_next  = 1'b0;
          timeout_next      = 1'b0;
        end
      end
      WAIT: begin
        if (react_e) false_start_next = 1'b1;
      end
      GO: begin
        if (react_e) begin
          result_ms_next    = ms_cnt_reg;
          result_valid_next = 1'b1;
        end else if (timeout_hit) begin
          timeout_next   = 1'b1;
          result_ms_next = 14'(TIMEOUT_MS);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
    ms_cnt_next    = ms_cnt_reg;
    if (tick && ((state_reg == WAIT) || (state_reg == GO))) begin
      ms_cnt_next = ms_cnt_reg + 14'd1;
    end
    if (entering) begin
      prescaler_next = '0;
      ms_cnt_next    = '0;
    end
  end

  // Edge registers reset high so a button held through reset yields no edge.
  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      start_q_reg      <= 1'b1;
      react_q_reg      <= 1'b1;
      prescaler_reg    <= '0;
      ms_cnt_reg       <= '0;
      delay_ms_reg     <= '0;
      led_reg          <= 1'b0;
      busy_reg         <= 1'b0;
      result_ms_reg    <= '0;
      result_valid_reg <= 1'b0;
      false_start_reg  <= 1'b0;
      timeout_reg      <= 1'b0;
      best_ms_reg      <= 14'h3FFF;
    end else begin
      start_q_reg      <= bus.start;
      react_q_reg      <= bus.react;
      prescaler_reg    <= prescaler_next;
      ms_cnt_reg       <= ms_cnt_next;
      delay_ms_reg     <= delay_ms_next;
      led_reg          <= led_next;
      busy_reg         <= busy_next;
      result_ms_reg    <= result_ms_next;
      result_valid_reg <= result_valid_next;
      false_start_reg  <= false_start_next;
      timeout_reg      <= timeout_next;
      best_ms_reg      <= best_ms_next;
    end
  end

  assign bus.led          = led_reg;
  assign bus.busy         = busy_reg;
  assign bus.result_ms    = result_ms_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.false_start  = false_start_reg;
  assign bus.timeout      = timeout_reg;
  assign bus.best_ms      = best_ms_reg;
  assign bus.state        = state_reg;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl: scenario tasks plus randomized
// rounds checked against a cycle-count model of the game rules.
module tb_reaction_game_ctrl;
  localparam int TD  = 4;
  localparam int MIN = 2;
  localparam int TO  = 10;

  logic cin = 1'b0;
  logic rst = 1'b1;
  reaction_game_ctrl_if bus();

  reaction_game_ctrl #(
    .TICK_DIV(TD),
    .MIN_DELAY_MS(MIN),
    .TIMEOUT_MS(TO)
  ) dut (
    .cin(cin),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 cin = ~cin;

  int checks = 0;
  int failures = 0;
  int best_model = 16'h3FFF;
  int last_result = 0;

  task automatic step();
    @(negedge cin);
  endtask

  // One full round. mode 0: press in GO at cycle k (k >= TD*TO means no press),
  // mode 1: press during WAIT at cycle k.
  task automatic play_round(input int r, input int mode, input int k);
    int cyc;
    int exp_res;
    int seen_led;
    bus.start = 1'b1;
    bus.rnd   = 12'(r);
    step();
    bus.start = 1'b0;
    bus.rnd   = 12'($urandom);
    checks++;
    if (bus.busy !== 1'b1 || bus.state !== 3'd1 || bus.result_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_entry busy=%0b state=%0d valid=%0b need busy=1 state=1 valid=0",
               bus.busy, bus.state, bus.result_valid);
    end
    if (mode == 1) begin
      repeat (k) step();
      bus.react = 1'b1;
      step();
      checks++;
      if (bus.state !== 3'd4 || bus.false_start !== 1'b1 || bus.led !== 1'b0 ||
          bus.busy !== 1'b0 || bus.timeout !== 1'b0 || bus.result_valid !== 1'b0) begin
        failures++;
        $display("FAIL false_start state=%0d fs=%0b led=%0b busy=%0b to=%0b valid=%0b need 4/1/0/0/0/0",
                 bus.state, bus.false_start, bus.led, bus.busy, bus.timeout, bus.result_valid);
      end
      checks++;
      if (bus.result_ms !== 14'(last_result) || bus.best_ms !== 14'(best_model)) begin
        failures++;
        $display("FAIL false_start_hold result=%0d best=%0d need result=%0d best=%0d",
                 bus.result_ms, bus.best_ms, last_result, best_model);
      end
      seen_led = 0;
      repeat ((MIN + r) * TD + 4) begin
        step();
        if (bus.led === 1'b1) seen_led = 1;
      end
      checks++;
      if (seen_led != 0 || bus.state !== 3'd4 || bus.best_ms !== 14'(best_model)) begin
        failures++;
        $display("FAIL no_led_after_fault seen_led=%0d state=%0d best=%0d need 0/4/%0d",
                 seen_led, bus.state, bus.best_ms, best_model);
      end
    end else begin
      cyc = 0;
      while (bus.led !== 1'b1 && cyc < 20000) begin
        step();
        cyc++;
      end
      checks++;
      if (cyc != (MIN + r) * TD || bus.state !== 3'd2 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL led_delay cycles=%0d state=%0d busy=%0b need cycles=%0d state=2 busy=1",
                 cyc, bus.state, bus.busy, (MIN + r) * TD);
      end
      if (k < TD * TO) begin
        repeat (k) step();
        bus.react = 1'b1;
        step();
        exp_res = k / TD;
        checks++;
        if (bus.state !== 3'd3 || bus.result_ms !== 14'(exp_res) || bus.result_valid !== 1'b1 ||
            bus.led !== 1'b0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
          failures++;
          $display("FAIL show_result state=%0d result=%0d valid=%0b led=%0b busy=%0b need 3/%0d/1/0/0",
                   bus.state, bus.result_ms, bus.result_valid, bus.led, bus.busy, exp_res);
        end
        checks++;
        if (bus.best_ms !== 14'(best_model)) begin
          failures++;
          $display("FAIL best_entry_cycle got=%0d need=%0d", bus.best_ms, best_model);
        end
        step();
        if (exp_res < best_model) best_model = exp_res;
        last_result = exp_res;
        checks++;
        if (bus.best_ms !== 14'(best_model)) begin
          failures++;
          $display("FAIL best_update got=%0d need=%0d", bus.best_ms, best_model);
        end
      end else begin
        repeat (TD * TO - 1) step();
        checks++;
        if (bus.state !== 3'd2 || bus.led !== 1'b1) begin
          failures++;
          $display("FAIL before_timeout state=%0d led=%0b need state=2 led=1", bus.state, bus.led);
        end
        step();
        last_result = TO;
        checks++;
        if (bus.state !== 3'd4 || bus.timeout !== 1'b1 || bus.result_ms !== 14'(TO) ||
            bus.result_valid !== 1'b0 || bus.false_start !== 1'b0 || bus.led !== 1'b0) begin
          failures++;
          $display("FAIL timeout state=%0d to=%0b result=%0d valid=%0b fs=%0b led=%0b need 4/1/%0d/0/0/0",
                   bus.state, bus.timeout, bus.result_ms, bus.result_valid, bus.false_start, bus.led, TO);
        end
        step();
        checks++;
        if (bus.best_ms !== 14'(best_model)) begin
          failures++;
          $display("FAIL timeout_best got=%0d need=%0d", bus.best_ms, best_model);
        end
      end
    end
    bus.react = 1'b0;
    step();
    step();
    $display("round rnd=%0d mode=%0d k=%0d result=%0d best=%0d state=%0d",
             r, mode, k, bus.result_ms, bus.best_ms, bus.state);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.react = 1'b0;
    bus.rnd   = 12'd0;
    repeat (3) step();
    checks++;
    if (bus.state !== 3'd0 || bus.led !== 1'b0 || bus.busy !== 1'b0 || bus.result_ms !== 14'd0) begin
      failures++;
      $display("FAIL reset_ctrl state=%0d led=%0b busy=%0b result=%0d need 0/0/0/0",
               bus.state, bus.led, bus.busy, bus.result_ms);
    end
    checks++;
    if (bus.result_valid !== 1'b0 || bus.false_start !== 1'b0 || bus.timeout !== 1'b0 ||
        bus.best_ms !== 14'h3FFF) begin
      failures++;
      $display("FAIL reset_flags valid=%0b fs=%0b to=%0b best=%0h need 0/0/0/3fff",
               bus.result_valid, bus.false_start, bus.timeout, bus.best_ms);
    end
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_first_round();
    play_round(3, 0, 4 * TD + 1);
  endtask

  task automatic test_best_tracking();
    play_round($urandom_range(0, 4), 0, 7 * TD + $urandom_range(0, TD - 1));
    play_round($urandom_range(0, 4), 0, $urandom_range(0, TD - 1));
  endtask

  task automatic test_false_start();
    play_round(2, 1, $urandom_range(0, (MIN + 2) * TD - 2));
    play_round(2, 1, (MIN + 2) * TD - 1);
  endtask

  task automatic test_timeout();
    play_round(1, 0, TD * TO);
    play_round(1, 0, TD * TO - 1);
  endtask

  task automatic test_random();
    int mode;
    int r;
    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 2);
      r    = $urandom_range(0, 6);
      if (mode == 1)      play_round(r, 1, $urandom_range(0, (MIN + r) * TD - 1));
      else if (mode == 2) play_round(r, 0, TD * TO);
      else                play_round(r, 0, $urandom_range(0, TD * TO + 3));
    end
  endtask

  task automatic test_reset_held_buttons();
    int cyc;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.react = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL held_start_no_edge state=%0d busy=%0b need 0/0", bus.state, bus.busy);
    end
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    bus.rnd   = 12'd1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.led !== 1'b1 && cyc < 20000) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != (MIN + 1) * TD || bus.state !== 3'd2 || bus.false_start !== 1'b0) begin
      failures++;
      $display("FAIL held_react_no_false_start cycles=%0d state=%0d fs=%0b need %0d/2/0",
               cyc, bus.state, bus.false_start, (MIN + 1) * TD);
    end
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.led !== 1'b0 || bus.state !== 3'd0 || bus.best_ms !== 14'h3FFF || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset led=%0b state=%0d best=%0h busy=%0b need 0/0/3fff/0",
               bus.led, bus.state, bus.best_ms, bus.busy);
    end
    bus.start = 1'b0;
    bus.react = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    bus.start = 1'b1;
    bus.react = 1'b1;
    step();
    bus.start = 1'b0;
    bus.react = 1'b0;
    checks++;
    if (bus.state !== 3'd1 || bus.false_start !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_react state=%0d fs=%0b need 1/0", bus.state, bus.false_start);
    end
    step();
    step();
    checks++;
    if (bus.state !== 3'd1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_persists state=%0d busy=%0b need 1/1", bus.state, bus.busy);
    end
    $display("round reset_held_buttons state=%0d best=%0h", bus.state, bus.best_ms);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_round();
    test_best_tracking();
    test_false_start();
    test_timeout();
    test_random();
    test_reset_held_buttons();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
Round controller for the reaction timer game. On a start press it samples the free-running 12-bit LFSR value and waits a pseudo-random delay in milliseconds. It then lights the stimulus LED and times the player's response in ms. It also flags false starts and timeouts, and keeps the best time since reset; its outputs feed the display/decoder logic.

Parameters:
TICK_DIV, 50000, cin cycles per 1 ms tick (50 MHz clock); sims use 4
MIN_DELAY_MS, 1000, fixed part of the pre-stimulus delay in ms
TIMEOUT_MS, 9999, maximum reaction time in ms before timeout

Ports:
cin  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-high reset
start  input  1  start button, synchronous debounced level; rising edge detected internally
react  input  1  player button, synchronous debounced level; rising edge detected internally
rnd  input  12  current LFSR value (free-running generator)
led  output  1  stimulus LED, 1 while measuring
busy  output  1  1 in WAIT or GO
result_ms  output  14  last reaction time in ms
result_valid  output  1  1 while result_ms holds a valid completed round
false_start  output  1  last round ended by a press before the stimulus
timeout  output  1  last round ended with no press within TIMEOUT_MS
best_ms  output  14  best valid result since reset; 14'h3FFF = none
state  output  3  FSM state for debug: IDLE=0, WAIT=1, GO=2, SHOW=3, FAULT=4

Behaviour:
- Reset (async, any state): state=IDLE; led=0; busy=0; result_ms=0; result_valid=0; false_start=0; timeout=0; best_ms=14'h3FFF; prescaler=0; ms_cnt=0.
- Reset also sets the edge-detect registers for start/react to 1. A button held through reset therefore gives no edge.
- Edges: start_e = start & ~start_q and react_e = react & ~react_q, using the previous-cycle registered level.
- Tick: a 1-cycle pulse when the prescaler reaches TICK_DIV-1. The prescaler then wraps to 0. Prescaler and ms_cnt are cleared on every state entry to WAIT or GO, so the first tick comes TICK_DIV cycles after entry.
- IDLE / SHOW / FAULT, on start_e:
  - Next state is WAIT.
  - delay_ms = MIN_DELAY_MS + rnd, 13-bit, latched this cycle.
  - result_valid, false_start and timeout are cleared; result_ms holds its value.
  - react_e in the same cycle is ignored.
- WAIT:
  - busy=1, led=0. Each tick increments ms_cnt.
  - On the tick where ms_cnt == delay_ms-1, go to GO.
  - react_e in WAIT, including on that same cycle, goes to FAULT with false_start=1. The press wins over the transition.
  - start_e is ignored.
- GO:
  - led=1 and busy=1 from the first cycle in GO. Each tick increments ms_cnt.
  - react_e goes to SHOW and captures result_ms = ms_cnt, the value before any tick that coincides with the press.
  - On the tick where ms_cnt == TIMEOUT_MS-1 with no press, go to FAULT with timeout=1 and result_ms=TIMEOUT_MS.
  - react_e has priority over a coincident timeout.
  - start_e is ignored.
- Entering SHOW: result_valid=1. If result_ms < best_ms, best_ms <= result_ms one cycle after entry; an equal value leaves best_ms unchanged.
- SHOW and FAULT: led=0, busy=0. Outputs are held until the next start_e.
- A 0 ms result is legal (press before the first tick in GO) and updates best_ms.
- All outputs are registered; there are no combinational paths from start, react or rnd to any output.

Test Plan:
1. TICK_DIV=4, MIN_DELAY_MS=2, rnd=3, start pulse -> busy=1 next cycle. led rises exactly 5*4=20 cycles after WAIT entry.
2. Press react 4 ticks + 1 cycle after led rises -> state=SHOW, result_ms=4, result_valid=1, best_ms=4.
3. Second round, press at ms_cnt=7 -> result_ms=7, best_ms stays 4. Third round, press with ms_cnt=0 -> result_ms=0, best_ms=0.
4. Press react during WAIT (including the cycle of the final delay tick) -> FAULT, false_start=1, led never asserts, best_ms unchanged.
5. TIMEOUT_MS=10, no press -> FAULT after 10 ticks in GO, timeout=1, result_ms=10. A press coincident with the 10th tick -> SHOW with result_ms=9.
6. Hold react high across rst deassert, then start -> no false start. Assert rst mid-GO -> led=0, state=IDLE and best_ms=14'h3FFF immediately, without waiting for a clock edge.
